spi_master_ctrl: RTL

- SPI master engine directly upstream of the SPI register readout mux.
- Owns the 32-bit control register and exports it as ctrl_reg_o. That output feeds the mux's control-register input.
- Runs byte-wide SPI mode-0 transfers. TX bytes are read from the data buffer and each RX byte is written back to the same buffer slot, so the data register contents reach the mux through the buffer.

---
 rtl/spi_master_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: owns the 32-bit control register and runs byte transfers.
// TX bytes come from the data buffer; RX bytes are written back into the same slot.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_ctrl_i,
  input  logic [31:0]       ctrl_wdata_i,
  output logic [31:0]       ctrl_reg_o,
  output logic [ADDR_W-1:0] buf_addr_o,
  input  logic [31:0]       buf_rdata_i,
  output logic [31:0]       buf_wdata_o,
  output logic              buf_we_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o,
  output logic [2:0]        dbg_state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0]        r_state;
  logic              r_send;
  logic              r_all_ones;
  logic              r_all_zeros;
  logic [8:0]        r_n_tx_end;
  logic [9:0]        r_n_rx_end;
  logic [8:0]        r_index;
  logic              r_load_ph;
  logic [7:0]        r_div;
  logic [3:0]        r_hcnt;
  logic [7:0]        r_tx_sr;
  logic [7:0]        r_rx_sr;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_cs_n;
  logic              r_we;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [31:0]       r_wdata;

  logic [7:0]        w_tx_byte;
  logic              w_unused;

  // all_ones wins over all_zeros; otherwise the buffer supplies the byte.
  assign w_tx_byte = r_all_ones  ? 8'hFF :
                     r_all_zeros ? 8'h00 : buf_rdata_i[7:0];
  assign w_unused  = &{1'b0, buf_rdata_i[31:8], ctrl_wdata_i[31:13], ctrl_wdata_i[3]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_send      <= 1'b0;
      r_all_ones  <= 1'b0;
      r_all_zeros <= 1'b0;
      r_n_tx_end  <= '0;
      r_n_rx_end  <= '0;
      r_index     <= '0;
      r_load_ph   <= 1'b0;
      r_div       <= '0;
      r_hcnt      <= '0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_we        <= 1'b0;
      r_buf_addr  <= '0;
      r_wdata     <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The bus strobe is a plain write: taken only while idle, no back-pressure.
          if (wr_ctrl_i) begin
            r_send      <= ctrl_wdata_i[0];
            r_all_ones  <= ctrl_wdata_i[1];
            r_all_zeros <= ctrl_wdata_i[2];
            r_n_tx_end  <= ctrl_wdata_i[12:4];
          end
          if (r_send) begin
            r_state    <= S_LOAD;
            r_index    <= '0;
            r_n_rx_end <= '0;
            r_cs_n     <= 1'b0;
            r_buf_addr <= '0;
            r_load_ph  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!r_load_ph) begin
            r_load_ph <= 1'b1;
          end else begin
            r_tx_sr <= w_tx_byte;
            r_mosi  <= w_tx_byte[7];
            r_div   <= '0;
            r_hcnt  <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_hcnt <= r_hcnt + 4'd1;
            if (!r_sclk) begin
              r_sclk  <= 1'b1;
              r_rx_sr <= {r_rx_sr[6:0], miso_i};
            end else begin
              r_sclk <= 1'b0;
              if (r_hcnt == 4'd15) begin
                r_state <= S_STORE;
                r_we    <= 1'b1;
                r_wdata <= {24'h0, r_rx_sr};
              end else begin
                r_mosi  <= r_tx_sr[6];
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_STORE: begin
          r_n_rx_end <= {1'b0, r_index} + 10'd1;
          if (r_index == r_n_tx_end) begin
            r_state <= S_DONE;
            r_cs_n  <= 1'b1;
            r_send  <= 1'b0;
            r_mosi  <= 1'b0;
          end else begin
            r_index    <= r_index + 9'd1;
            r_buf_addr <= ADDR_W'(r_index + 9'd1);
            r_load_ph  <= 1'b0;
            r_state    <= S_LOAD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ctrl_reg_o  = {6'b0, r_n_rx_end, 3'b0, r_n_tx_end, 1'b0, r_all_zeros, r_all_ones, r_send};
  assign buf_addr_o  = r_buf_addr;
  assign buf_wdata_o = r_wdata;
  assign buf_we_o    = r_we;
  assign sclk_o      = r_sclk;
  assign mosi_o      = r_mosi;
  assign cs_n_o      = r_cs_n;
  assign dbg_state_o = r_state;

endmodule
